// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and an internal Z/V/N flag register.
// Stage 1 captures opcode and operands, stage 2 captures the computed result.
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int LANE   = 4,
    parameter int SAT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int NLANE = WIDTH / LANE;
    localparam int NBYTE = WIDTH / 8;
    localparam logic [SHW:0] WIDTH_L = (SHW+1)'(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
        OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
        OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB
    } op_e;

    logic             s1_v_q, s1_v_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;

    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_err_q, s2_err_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic             s2_upd_zvn_q, s2_upd_zvn_d;
    logic             s2_upd_z_q, s2_upd_z_d;

    logic             flag_z_q, flag_z_d, flag_v_q, flag_v_d, flag_n_q, flag_n_d;

    logic             s1_free, s2_free, out_fire;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] add_sum, sub_diff, red_sum, padd_result, ror_result;
    logic             add_ovf, sub_ovf;
    logic [LANE-1:0]  lane_a, lane_b, lane_s;
    logic [WIDTH-1:0] alu_result;
    logic             alu_err, alu_ovf, alu_upd_zvn, alu_upd_z;

    function automatic logic [WIDTH-1:0] sat_val(input logic neg);
        sat_val = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign s2_free  = !s2_v_q || out_ready;
    assign s1_free  = !s1_v_q || s2_free;
    assign in_ready = s1_free && !flush;
    assign out_fire = s2_v_q && out_ready;

    assign shamt    = s1_b_q[SHW-1:0];
    assign add_sum  = s1_a_q + s1_b_q;
    assign sub_diff = s1_a_q - s1_b_q;
    // Overflow means the true result's sign (always A's sign here) differs from the wrapped one.
    assign add_ovf  = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (add_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
    assign sub_ovf  = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (sub_diff[WIDTH-1] != s1_a_q[WIDTH-1]);
    assign ror_result = (s1_a_q >> shamt) | (s1_a_q << (WIDTH_L - {1'b0, shamt}));

    always_comb begin
        red_sum = '0;
        for (int i = 0; i < NBYTE; i++) begin
            red_sum = red_sum
                    + {{(WIDTH-8){s1_a_q[8*i+7]}}, s1_a_q[8*i +: 8]}
                    + {{(WIDTH-8){s1_b_q[8*i+7]}}, s1_b_q[8*i +: 8]};
        end
    end

    always_comb begin
        padd_result = '0;
        lane_a      = '0;
        lane_b      = '0;
        lane_s      = '0;
        for (int l = 0; l < NLANE; l++) begin
            lane_a = s1_a_q[l*LANE +: LANE];
            lane_b = s1_b_q[l*LANE +: LANE];
            lane_s = lane_a + lane_b;
            if ((lane_a[LANE-1] == lane_b[LANE-1]) && (lane_s[LANE-1] != lane_a[LANE-1])) begin
                lane_s = lane_a[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
            end
            padd_result[l*LANE +: LANE] = lane_s;
        end
    end

    always_comb begin
        alu_result  = '0;
        alu_err     = 1'b0;
        alu_ovf     = 1'b0;
        alu_upd_zvn = 1'b0;
        alu_upd_z   = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                alu_ovf     = add_ovf;
                alu_upd_zvn = 1'b1;
                alu_result  = ((SAT_EN != 0) && add_ovf) ? sat_val(s1_a_q[WIDTH-1]) : add_sum;
            end
            OP_SUB: begin
                alu_ovf     = sub_ovf;
                alu_upd_zvn = 1'b1;
                alu_result  = ((SAT_EN != 0) && sub_ovf) ? sat_val(s1_a_q[WIDTH-1]) : sub_diff;
            end
            OP_XOR: begin
                alu_result = s1_a_q ^ s1_b_q;
                alu_upd_z  = 1'b1;
            end
            OP_RED:    alu_result = red_sum;
            OP_SLL: begin
                alu_result = s1_a_q << shamt;
                alu_upd_z  = 1'b1;
            end
            OP_SRA: begin
                alu_result = $signed(s1_a_q) >>> shamt;
                alu_upd_z  = 1'b1;
            end
            OP_ROR: begin
                alu_result = ror_result;
                alu_upd_z  = 1'b1;
            end
            OP_PADDSB: alu_result = padd_result;
            OP_LW, OP_SW: alu_result = (s1_a_q & ~{{(WIDTH-1){1'b0}}, 1'b1}) + {s1_b_q[WIDTH-2:0], 1'b0};
            OP_LLB:    alu_result = {s1_a_q[WIDTH-1:8], s1_b_q[7:0]};
            OP_LHB: begin
                alu_result        = s1_a_q;
                alu_result[15:8]  = s1_b_q[7:0];
            end
            default:   alu_err = 1'b1;
        endcase
    end

    // A stage only advances when the stage after it can take its contents; flush empties both.
    always_comb begin
        s1_v_d       = s1_v_q;
        s1_op_d      = s1_op_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s2_v_d       = s2_v_q;
        s2_result_d  = s2_result_q;
        s2_err_d     = s2_err_q;
        s2_ovf_d     = s2_ovf_q;
        s2_upd_zvn_d = s2_upd_zvn_q;
        s2_upd_z_d   = s2_upd_z_q;
        if (s1_free) begin
            s1_v_d = in_valid && !flush;
            if (in_valid && !flush) begin
                s1_op_d = in_opcode;
                s1_a_d  = in_a;
                s1_b_d  = in_b;
            end
        end
        if (s2_free) begin
            s2_v_d = s1_v_q && !flush;
            if (s1_v_q) begin
                s2_result_d  = alu_result;
                s2_err_d     = alu_err;
                s2_ovf_d     = alu_ovf;
                s2_upd_zvn_d = alu_upd_zvn;
                s2_upd_z_d   = alu_upd_z;
            end
        end
        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end
    end

    always_comb begin
        flag_z_d = flag_z_q;
        flag_v_d = flag_v_q;
        flag_n_d = flag_n_q;
        if (out_fire && s2_upd_zvn_q) begin
            flag_z_d = (s2_result_q == '0);
            flag_v_d = s2_ovf_q;
            flag_n_d = s2_result_q[WIDTH-1];
        end else if (out_fire && s2_upd_z_q) begin
            flag_z_d = (s2_result_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q       <= 1'b0;
            s1_op_q      <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s2_v_q       <= 1'b0;
            s2_result_q  <= '0;
            s2_err_q     <= 1'b0;
            s2_ovf_q     <= 1'b0;
            s2_upd_zvn_q <= 1'b0;
            s2_upd_z_q   <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_v_q     <= 1'b0;
            flag_n_q     <= 1'b0;
        end else begin
            s1_v_q       <= s1_v_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s2_v_q       <= s2_v_d;
            s2_result_q  <= s2_result_d;
            s2_err_q     <= s2_err_d;
            s2_ovf_q     <= s2_ovf_d;
            s2_upd_zvn_q <= s2_upd_zvn_d;
            s2_upd_z_q   <= s2_upd_z_d;
            flag_z_q     <= flag_z_d;
            flag_v_q     <= flag_v_d;
            flag_n_q     <= flag_n_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign out_result = s2_result_q;
    assign out_err    = s2_err_q;
    assign flag_z     = flag_z_q;
    assign flag_v     = flag_v_q;
    assign flag_n     = flag_n_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases, stall/flush/reset scenarios and random traffic.
// Expected results come from an integer-arithmetic model of the instruction set.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = '0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_err;
    logic        flag_z, flag_v, flag_n;

    alu_pipe #(.WIDTH(16), .LANE(4), .SAT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] result;
        logic        err;
        logic [3:0]  op;
        logic        ovf;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   vectorCount = 0;
    int   missCount = 0;
    logic modelZ = 1'b0, modelV = 1'b0, modelN = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic exp_t refModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   sa, sb, s;
        logic [15:0] r;
        e.op = op; e.err = 1'b0; e.ovf = 1'b0; e.result = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            4'h0, 4'h1: begin
                s = (op == 4'h0) ? sa + sb : sa - sb;
                if (s > 32767)       begin e.ovf = 1'b1; e.result = 16'h7FFF; end
                else if (s < -32768) begin e.ovf = 1'b1; e.result = 16'h8000; end
                else                 e.result = 16'(s);
            end
            4'h2: e.result = a ^ b;
            4'h3: begin
                s = 0;
                for (int i = 0; i < 2; i++)
                    s = s + int'($signed(a[8*i +: 8])) + int'($signed(b[8*i +: 8]));
                e.result = 16'(s);
            end
            4'h4: e.result = a << b[3:0];
            4'h5: e.result = 16'(sa >>> b[3:0]);
            4'h6: begin
                r = a;
                for (int i = 0; i < int'(b[3:0]); i++) r = {r[0], r[15:1]};
                e.result = r;
            end
            4'h7: begin
                for (int l = 0; l < 4; l++) begin
                    s = int'($signed(a[4*l +: 4])) + int'($signed(b[4*l +: 4]));
                    if (s > 7) s = 7;
                    else if (s < -8) s = -8;
                    e.result[4*l +: 4] = 4'(s);
                end
            end
            4'h8, 4'h9: e.result = 16'(int'(a & 16'hFFFE) + 2 * int'(b));
            4'hA: e.result = {a[15:8], b[7:0]};
            4'hB: e.result = {b[7:0], a[7:0]};
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Monitor: pops on each output handshake, then checks the committed flags after the edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    vectorCount++;
                    missCount++;
                    $display("[TB] FAIL unexpected_output: got result 0x%0h with nothing outstanding", out_result);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput($sformatf("result_op%0h", monE.op), out_result, monE.result);
                    checkOutput($sformatf("err_op%0h", monE.op), out_err, monE.err);
                    if (monE.op <= 4'h1) begin
                        modelZ = (monE.result == 16'h0);
                        modelV = monE.ovf;
                        modelN = monE.result[15];
                    end else if (monE.op == 4'h2 || monE.op == 4'h4 || monE.op == 4'h5 || monE.op == 4'h6) begin
                        modelZ = (monE.result == 16'h0);
                    end
                    @(posedge clk);
                    #1;
                    checkOutput($sformatf("flags_op%0h", monE.op), {flag_z, flag_v, flag_n}, {modelZ, modelV, modelN});
                end
            end
        end
    end

    // Starts at a negedge, holds the op until accepted, returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bit taken = 1'b0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        for (int i = 0; i < 100 && !taken; i++) begin
            #1;
            taken = in_ready;
            @(posedge clk);
            if (taken) expQ.push_back(refModel(op, a, b));
            @(negedge clk);
        end
        if (!taken) begin
            vectorCount++;
            missCount++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] pick [4];
        bit accepted;
        pick[0] = 16'h7FFF; pick[1] = 16'h8000; pick[2] = 16'hFFFF; pick[3] = 16'h0000;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_result", out_result, 0);
        checkOutput("rst_out_err", out_err, 0);
        checkOutput("rst_flags", {flag_z, flag_v, flag_n}, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // Directed operations, back-to-back with the consumer always ready.
        out_ready = 1'b1;
        @(negedge clk);
        applyStimulus(4'h0, 16'h7FFF, 16'h0001);
        in_valid = 1'b0;
        #1 checkOutput("lat_add_1clk", out_valid, 0);
        @(negedge clk);
        #1 checkOutput("lat_add_2clk", out_valid, 1);
        @(negedge clk);
        applyStimulus(4'h1, 16'h8000, 16'h0001);
        applyStimulus(4'h2, 16'h1234, 16'h1234);
        applyStimulus(4'h7, 16'h7878, 16'h1818);
        applyStimulus(4'h6, 16'h8001, 16'h0001);
        applyStimulus(4'h8, 16'h1001, 16'h0003);
        applyStimulus(4'hA, 16'hABCD, 16'h0012);
        applyStimulus(4'hB, 16'hABCD, 16'h0034);
        applyStimulus(4'h3, 16'h80FF, 16'h7F01);
        applyStimulus(4'h4, 16'h00F1, 16'h0004);
        applyStimulus(4'h5, 16'h8F00, 16'h0004);
        applyStimulus(4'h1, 16'h0005, 16'h0005);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Stall: two ops fill the pipe, the third is refused until the consumer drains.
        out_ready = 1'b0;
        applyStimulus(4'h0, 16'h0001, 16'h0002);
        applyStimulus(4'h1, 16'h0010, 16'h0003);
        in_opcode = 4'h2; in_a = 16'h00F0; in_b = 16'h0F0F; in_valid = 1'b1;
        #1;
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        applyStimulus(4'h2, 16'h00F0, 16'h0F0F);
        in_valid = 1'b0;
        #1 checkOutput("drain_valid_1", out_valid, 1);
        @(negedge clk);
        #1 checkOutput("drain_valid_2", out_valid, 1);
        @(negedge clk);
        #1 checkOutput("drain_valid_3", out_valid, 0);
        repeat (2) @(negedge clk);

        // Flush with both stages full and a new op offered in the same cycle.
        out_ready = 1'b0;
        applyStimulus(4'h0, 16'h7FFF, 16'h7FFF);
        applyStimulus(4'h1, 16'h0000, 16'h0000);
        flush = 1'b1;
        in_valid = 1'b1; in_opcode = 4'h0; in_a = 16'h1111; in_b = 16'h2222;
        #1 checkOutput("flush_in_ready", in_ready, 0);
        @(posedge clk);
        expQ.delete();
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_flags_held", {flag_z, flag_v, flag_n}, {modelZ, modelV, modelN});
        out_ready = 1'b1;
        @(negedge clk);
        #1 checkOutput("flush_nothing_accepted", out_valid, 0);
        applyStimulus(4'hE, 16'h1234, 16'h5678);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset pulse with ops in flight.
        applyStimulus(4'h1, 16'h8000, 16'h0001);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(4'h0, 16'h1234, 16'h1111);
        applyStimulus(4'h2, 16'hFFFF, 16'h0000);
        in_valid = 1'b0;
        @(posedge clk);
        #2 checkOutput("pre_reset_out_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", out_valid, 0);
        checkOutput("async_rst_out_result", out_result, 0);
        checkOutput("async_rst_flags", {flag_z, flag_v, flag_n}, 0);
        expQ.delete();
        modelZ = 1'b0; modelV = 1'b0; modelN = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        applyStimulus(4'h2, 16'h00FF, 16'h0F0F);
        in_valid = 1'b0;
        #1 checkOutput("post_rst_lat_1clk", out_valid, 0);
        @(negedge clk);
        #1 checkOutput("post_rst_lat_2clk", out_valid, 1);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_opcode = 4'($urandom_range(0, 15));
            in_a      = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            in_b      = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            #1;
            accepted = in_valid && in_ready;
            @(posedge clk);
            if (accepted) expQ.push_back(refModel(in_opcode, in_a, in_b));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput("drain_empty", expQ.size(), 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
